br_writeback: RTL and testbench
===============================

Name: br_writeback

Overview:
Write-back stage and register bank that sits directly downstream of the pulse counter. It queues register-bank write requests, up to 2 deep. One queued write is committed to the register array on each commit slot (selector_demux high for one cycle). It also provides two combinational read ports to the ALU/decode stage. The data source for each write is selected per request: ALU result or memory read data.

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers; address width is AW = clog2(DEPTH)
- ZERO_REG, 1, when 1, register 0 reads as zero and writes to it are discarded

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- selector_demux  input  1  commit-slot pulse from the counter stage; high for one cycle in every three
- i_e_write_br  input  1  write request strobe; one request per cycle it is high
- i_sel_src  input  1  source select: 0 = i_dato_alu, 1 = i_dato_mem
- i_dir_write  input  AW  destination register address
- i_dato_alu  input  WIDTH  ALU result
- i_dato_mem  input  WIDTH  memory read data
- i_dir_read1  input  AW  read port 1 address
- i_dir_read2  input  AW  read port 2 address
- o_dato1  output  WIDTH  read port 1 data (combinational)
- o_dato2  output  WIDTH  read port 2 data (combinational)
- o_full  output  1  pending queue holds 2 entries
- o_drop  output  1  registered; one-cycle pulse when a request was rejected
- o_write_done  output  1  registered; one-cycle pulse on the cycle after a commit

Behaviour:
- Capture: the source mux is resolved at capture time. A queue entry stores {addr, data}, where data = i_sel_src ? i_dato_mem : i_dato_alu, sampled on the accepting edge.
- Queue: 2-entry FIFO with count 0..2 and a head pointer that wraps modulo 2. Head-oldest ordering is guaranteed.
- Accept rule: a request is accepted when i_e_write_br=1 and (count<2, or a commit occurs in the same cycle).
- Rejected request: o_drop pulses 1 on the next cycle. The queue is unchanged.
- Commit: on a cycle with selector_demux=1 and count>0, the head entry is written to the array at the edge, the head advances, and o_write_done=1 on the following cycle.
- Commit with an empty queue: no effect; o_write_done stays 0.
- Push and commit in the same cycle: both happen. Count is unchanged, and the new entry lands behind the remaining entries. With count=2, the push is accepted, not dropped.
- Commit and push are never merged: a request arriving in a commit cycle is never written in that same cycle.
- ZERO_REG=1: a write to address 0 is still queued and still consumes a slot and a commit. The array write is suppressed, but o_write_done still pulses. Reads of address 0 return 0.
- Addresses >= DEPTH (non-power-of-2 DEPTH): writes are discarded at commit; reads return 0.
- Reads are combinational from the array, with no forwarding (see Optional Feature).
- FSM (derived from count): EMPTY(0) -> ONE on push; ONE -> TWO on push without commit; ONE -> EMPTY on commit without push; TWO -> ONE on commit without push. All other combinations hold the state.
- Reset (synchronous, highest priority, including mid-queue): count=0, head=0, all array registers=0, o_drop=0, o_write_done=0, o_full=0. Pending entries are discarded, and a request presented during the reset cycle is ignored.

Optional Feature:
- Macro: BR_BYPASS_EN.
- Defined: a read port whose address matches a pending queue entry returns the youngest matching entry's data instead of the array value. Address 0 is never forwarded when ZERO_REG=1. Forwarding is combinational and adds one compare per entry per port.
- Undefined: reads return array contents only. A queued write becomes visible the cycle after its commit.

Decomposition:
- Shared package br_pkg:
  - WIDTH and DEPTH defaults
  - typedef br_addr_t
  - typedef br_data_t
  - struct br_wr_entry_t {addr, data}
  - localparams SRC_ALU=0 and SRC_MEM=1
- One natural sub-module: br_wr_queue, the 2-entry FIFO with push/pop/full/count and entry visibility for bypass. br_writeback instantiates it plus the array and read muxes.

Test Plan:
1. Reset, then read all addresses -> o_dato1 = o_dato2 = 0; o_full=0; no pulses on o_drop or o_write_done.
2. Single write, source ALU, addr 5, data 0xDEADBEEF, two cycles before a commit pulse -> o_dato1 reads 0xDEADBEEF with i_dir_read1=5 the cycle after the commit, and o_write_done pulses once.
3. Three back-to-back requests, no commit pulse: addr 1 = 0x11 (MEM), addr 2 = 0x22 (MEM), addr 3 = 0x33 -> o_full=1 after the 2nd request, o_drop pulses on the 3rd, and the next two commits write 0x11 then 0x22 in order.
4. Queue full, request (addr 4, 0x44) arrives in the same cycle as selector_demux -> no drop; addr 1 is committed now and addr 4 is committed on a later pulse.
5. Write 0xFF to addr 0 with ZERO_REG=1 -> o_write_done pulses and a read of addr 0 returns 0. With BR_BYPASS_EN defined, a queued write of 0x77 to addr 6 reads 0x77 before its commit.
6. Assert reset with 2 entries pending -> the next commit pulse writes nothing, count=0, and all registers read 0.

Source files
------------

// File: rtl/br_pkg.sv
// br_pkg: shared defaults, types and queue states for the write-back stage.
// Forwarding from the pending queue is enabled with BR_BYPASS_EN.
package br_pkg;

  localparam int BR_WIDTH = 32;
  localparam int BR_DEPTH = 32;
  localparam int BR_AW    = $clog2(BR_DEPTH);

  typedef logic [BR_AW-1:0]    br_addr_t;
  typedef logic [BR_WIDTH-1:0] br_data_t;

  typedef struct packed {
    br_addr_t addr;
    br_data_t data;
  } br_wr_entry_t;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } br_q_state_t;

  function automatic int br_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/br_writeback_if.sv
// br_writeback_if: write-request, commit-slot and read-port bundle.
// master drives requests and read addresses; slave is the register bank.
interface br_writeback_if
  import br_pkg::*;
#(
  parameter int WIDTH = BR_WIDTH,
  parameter int DEPTH = BR_DEPTH
);

  localparam int AW = br_aw(DEPTH);

  logic             selector_demux;
  logic             i_e_write_br;
  logic             i_sel_src;
  logic [AW-1:0]    i_dir_write;
  logic [WIDTH-1:0] i_dato_alu;
  logic [WIDTH-1:0] i_dato_mem;
  logic [AW-1:0]    i_dir_read1;
  logic [AW-1:0]    i_dir_read2;
  logic [WIDTH-1:0] o_dato1;
  logic [WIDTH-1:0] o_dato2;
  logic             o_full;
  logic             o_drop;
  logic             o_write_done;

  modport master (
    output selector_demux,
    output i_e_write_br,
    output i_sel_src,
    output i_dir_write,
    output i_dato_alu,
    output i_dato_mem,
    output i_dir_read1,
    output i_dir_read2,
    input  o_dato1,
    input  o_dato2,
    input  o_full,
    input  o_drop,
    input  o_write_done
  );

  modport slave (
    input  selector_demux,
    input  i_e_write_br,
    input  i_sel_src,
    input  i_dir_write,
    input  i_dato_alu,
    input  i_dato_mem,
    input  i_dir_read1,
    input  i_dir_read2,
    output o_dato1,
    output o_dato2,
    output o_full,
    output o_drop,
    output o_write_done
  );

endinterface

// File: rtl/br_wr_queue.sv
// br_wr_queue: 2-entry write FIFO; a pop frees its slot for a same-cycle push.
// Both entries are exposed (oldest/youngest) so reads can forward from them.
module br_wr_queue
  import br_pkg::*;
#(
  parameter int WIDTH = BR_WIDTH,
  parameter int AW    = BR_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic             accept,
  output logic             pop,
  output logic             full,
  output logic             vld_old,
  output logic             vld_new,
  output logic [AW-1:0]    addr_old,
  output logic [WIDTH-1:0] data_old,
  output logic [AW-1:0]    addr_new,
  output logic [WIDTH-1:0] data_new
);

  br_q_state_t state_q;
  br_q_state_t state_d;

  logic             head_q;
  logic             tail;
  logic [AW-1:0]    addr_q [2];
  logic [WIDTH-1:0] data_q [2];

  always_ff @(posedge clk) begin
    if (reset) state_q <= Q_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Q_EMPTY: begin
        if (accept) state_d = Q_ONE;
      end
      Q_ONE: begin
        if (accept && !pop)      state_d = Q_TWO;
        else if (pop && !accept) state_d = Q_EMPTY;
      end
      Q_TWO: begin
        if (pop && !accept) state_d = Q_ONE;
      end
      default: state_d = Q_EMPTY;
    endcase
  end

  // When full, a push is only taken if the head drains in the same cycle.
  always_comb begin
    pop     = 1'b0;
    accept  = 1'b0;
    full    = 1'b0;
    vld_old = 1'b0;
    vld_new = 1'b0;
    unique case (state_q)
      Q_EMPTY: begin
        accept = push;
      end
      Q_ONE: begin
        pop     = pop_req;
        accept  = push;
        vld_old = 1'b1;
      end
      Q_TWO: begin
        pop     = pop_req;
        accept  = push & pop_req;
        full    = 1'b1;
        vld_old = 1'b1;
        vld_new = 1'b1;
      end
      default: ;
    endcase
  end

  // head+count mod 2; with two entries this is the slot being popped.
  assign tail = head_q ^ (state_q == Q_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
      end
      if (pop) head_q <= ~head_q;
    end
  end

  assign addr_old = addr_q[head_q];
  assign data_old = data_q[head_q];
  assign addr_new = addr_q[~head_q];
  assign data_new = data_q[~head_q];

endmodule

// File: rtl/br_writeback.sv
// br_writeback: queued register-bank write-back with two combinational reads.
// Define BR_BYPASS_EN to forward pending queue entries to the read ports.
module br_writeback
  import br_pkg::*;
#(
  parameter int WIDTH    = BR_WIDTH,
  parameter int DEPTH    = BR_DEPTH,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  br_writeback_if.slave bus
);

  localparam int AW = br_aw(DEPTH);

  logic [WIDTH-1:0] wr_data;
  logic             q_accept;
  logic             q_pop;
  logic             q_full;
  logic             q_vld_old;
  logic             q_vld_new;
  logic [AW-1:0]    q_addr_old;
  logic [WIDTH-1:0] q_data_old;
  logic [AW-1:0]    q_addr_new;
  logic [WIDTH-1:0] q_data_new;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             drop_q;
  logic             done_q;

  logic [AW-1:0]    rd_a [2];
  logic [WIDTH-1:0] rd_d [2];

  // Address decodes to a real, writable register.
  function automatic logic live(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_data = (bus.i_sel_src == SRC_MEM) ? bus.i_dato_mem
                                              : bus.i_dato_alu;

  br_wr_queue #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_wr_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.i_e_write_br),
    .push_addr (bus.i_dir_write),
    .push_data (wr_data),
    .pop_req   (bus.selector_demux),
    .accept    (q_accept),
    .pop       (q_pop),
    .full      (q_full),
    .vld_old   (q_vld_old),
    .vld_new   (q_vld_new),
    .addr_old  (q_addr_old),
    .data_old  (q_data_old),
    .addr_new  (q_addr_new),
    .data_new  (q_data_new)
  );

  // The committed entry is always the oldest one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (q_pop && live(q_addr_old)) begin
      regs[q_addr_old] <= q_data_old;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      drop_q <= bus.i_e_write_br & ~q_accept;
      done_q <= q_pop;
    end
  end

  assign rd_a[0] = bus.i_dir_read1;
  assign rd_a[1] = bus.i_dir_read2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = '0;
      if (live(rd_a[p])) begin
        rd_d[p] = regs[rd_a[p]];
`ifdef BR_BYPASS_EN
        if (q_vld_old && (q_addr_old == rd_a[p])) rd_d[p] = q_data_old;
        if (q_vld_new && (q_addr_new == rd_a[p])) rd_d[p] = q_data_new;
`endif
      end
    end
  end

`ifndef BR_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{q_vld_new, q_addr_new, q_data_new};
`endif

  assign bus.o_dato1      = rd_d[0];
  assign bus.o_dato2      = rd_d[1];
  assign bus.o_full       = q_full;
  assign bus.o_drop       = drop_q;
  assign bus.o_write_done = done_q;

endmodule

// File: tb/tb_br_writeback.sv
// tb_br_writeback: directed plan steps then random traffic against a
// queue/array reference model of the write-back stage.
module tb_br_writeback;
  import br_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  br_writeback_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

  br_writeback #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .ZERO_REG (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  br_wr_entry_t q[$];
  logic [31:0]  arr [DEPTH];
  logic         exp_drop;
  logic         exp_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mref(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || int'(a) >= DEPTH) return 32'd0;
    v = arr[a];
`ifdef BR_BYPASS_EN
    foreach (q[i]) if (q[i].addr == a) v = q[i].data;
`endif
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) arr[i] = 32'd0;
    exp_drop = 1'b0;
    exp_done = 1'b0;
  endtask

  // One clock: drive, check current state, clock, update the model.
  task automatic cyc(input logic rs, input logic sel, input logic we,
                     input logic src, input logic [4:0] wa,
                     input logic [31:0] alu, input logic [31:0] mem,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit commit;
    bit acc;
    br_wr_entry_t e;
    reset              = rs;
    bus.selector_demux = sel;
    bus.i_e_write_br   = we;
    bus.i_sel_src      = src;
    bus.i_dir_write    = wa;
    bus.i_dato_alu     = alu;
    bus.i_dato_mem     = mem;
    bus.i_dir_read1    = r1;
    bus.i_dir_read2    = r2;
    #1;
    chk("full", {31'd0, bus.o_full}, {31'd0, q.size() == 2});
    chk("drop", {31'd0, bus.o_drop}, {31'd0, exp_drop});
    chk("done", {31'd0, bus.o_write_done}, {31'd0, exp_done});
    chk("rd1", bus.o_dato1, mref(r1));
    chk("rd2", bus.o_dato2, mref(r2));
    commit = sel && q.size() > 0;
    acc    = we && (q.size() < 2 || commit);
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (commit) begin
        e = q.pop_front();
        if (e.addr != 5'd0 && int'(e.addr) < DEPTH) arr[e.addr] = e.data;
      end
      if (acc) q.push_back('{addr: wa, data: src ? mem : alu});
      exp_drop = we && !acc;
      exp_done = commit;
    end
    #1;
  endtask

  task automatic probe(input string tag, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] e1,
                       input logic [31:0] e2);
    bus.i_dir_read1 = r1;
    bus.i_dir_read2 = r2;
    #1;
    chk(tag, bus.o_dato1, e1);
    chk(tag, bus.o_dato2, e2);
  endtask

  initial begin
    reset              = 1'b1;
    bus.selector_demux = 1'b0;
    bus.i_e_write_br   = 1'b0;
    bus.i_sel_src      = 1'b0;
    bus.i_dir_write    = '0;
    bus.i_dato_alu     = '0;
    bus.i_dato_mem     = '0;
    bus.i_dir_read1    = '0;
    bus.i_dir_read2    = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state and empty commits
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, (i % 3) == 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk("t1_zero", bus.o_dato1, 32'd0);
    end

    // single ALU write then commit
    cyc(0, 0, 1, SRC_ALU, 5, 32'hDEADBEEF, 32'h1, 5, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 5);
    cyc(0, 1, 0, 0, 0, 0, 0, 5, 5);
    chk("t2_done", {31'd0, bus.o_write_done}, 32'd1);
    probe("t2_rd5", 5, 0, 32'hDEADBEEF, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 5);

    // fill, overflow drop
    cyc(0, 0, 1, SRC_MEM, 1, 32'hAA, 32'h11, 1, 2);
    cyc(0, 0, 1, SRC_MEM, 2, 32'hBB, 32'h22, 1, 2);
    chk("t3_full", {31'd0, bus.o_full}, 32'd1);
    cyc(0, 0, 1, SRC_ALU, 3, 32'h33, 32'h0, 1, 3);
    chk("t3_drop", {31'd0, bus.o_drop}, 32'd1);

    // push into full queue on a commit slot
    cyc(0, 1, 1, SRC_ALU, 4, 32'h44, 32'h0, 1, 2);
    chk("t4_nodrop", {31'd0, bus.o_drop}, 32'd0);
    chk("t4_full", {31'd0, bus.o_full}, 32'd1);
    probe("t4_rd1", 1, 2, 32'h11, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 2, 4);
    probe("t4_rd2", 2, 4, 32'h22, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 4, 3);
    probe("t4_rd4", 4, 3, 32'h44, 32'd0);

    // zero register and bypass
    cyc(0, 0, 1, SRC_ALU, 0, 32'hFF, 32'h0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_done", {31'd0, bus.o_write_done}, 32'd1);
    probe("t5_rd0", 0, 0, 32'd0, 32'd0);
    cyc(0, 0, 1, SRC_ALU, 6, 32'h77, 32'h0, 6, 6);
`ifdef BR_BYPASS_EN
    probe("t5_byp", 6, 6, 32'h77, 32'h77);
`else
    probe("t5_nobyp", 6, 6, 32'd0, 32'd0);
`endif
    cyc(0, 1, 0, 0, 0, 0, 0, 6, 6);
    probe("t5_rd6", 6, 0, 32'h77, 32'd0);

    // reset with two pending
    cyc(0, 0, 1, SRC_ALU, 7, 32'h7777, 32'h0, 7, 8);
    cyc(0, 0, 1, SRC_MEM, 8, 32'h0, 32'h8888, 7, 8);
    chk("t6_full", {31'd0, bus.o_full}, 32'd1);
    cyc(1, 0, 1, SRC_ALU, 9, 32'h9999, 32'h0, 7, 8);
    chk("t6_rfull", {31'd0, bus.o_full}, 32'd0);
    chk("t6_rdrop", {31'd0, bus.o_drop}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 7, 8);
    chk("t6_nodone", {31'd0, bus.o_write_done}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk("t6_zero", bus.o_dato2, 32'd0);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 99) == 0,
          ((n % 3) == 0) ^ ($urandom_range(0, 9) == 0),
          $urandom_range(0, 99) < 65,
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          $urandom, $urandom,
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
